fifo_rd_port: RTL and testbench
===============================

# fifo_rd_port

Read end of the 8-deep × 32-bit FIFO. The write side stores words into a bank of eight enabled 32-bit registers and pulses `wr_ack` for each stored word. This block owns the read pointer, the occupancy count and the empty/full flags, and returns one word per accepted read request. It uses a registered output and read handshake, with error signalling for reads from an empty FIFO.

## Interface
- No parameters. Fixed values: depth 8, word width 32, pointer 3 bits, count 4 bits.
- `clk` — input, 1 — Single clock; all state changes on the rising edge.
- `reset_n` — input, 1 — Reset is asynchronous and active-low.
- `rd_en` — input, 1 — Read request, sampled on each rising edge.
- `wr_ack` — input, 1 — One-cycle pulse from the write side: one word was stored at `wr_ptr` this edge.
- `reg_bank` — input, 256 — Flattened register-bank outputs; entry i occupies bits [32i+31:32i].
- `d_out` — output, 32 — Read data.
- `rd_ack` — output, 1 — The read succeeded this cycle.
- `rd_err` — output, 1 — A read was attempted while the FIFO was empty.
- `rd_ptr` — output, 3 — Index of the next entry to read. The write side uses it.
- `data_count` — output, 4 — Occupancy, range 0..8.
- `empty` — output, 1 — High when `data_count` is 0.
- `full` — output, 1 — High when `data_count` is 8.

## Operation
- FSM states: INIT, NO_OP, READ, RD_ERROR. The state is registered and reflected on the registered outputs.
- INIT:
  - Entered on reset.
  - Always moves to NO_OP on the next edge.
  - `rd_en` is ignored while in INIT.
- NO_OP / READ / RD_ERROR. Next state is decided from `rd_en` and the current `data_count`:
  - `rd_en`=0 → NO_OP.
  - `rd_en`=1 and `data_count`>0 → READ.
  - `rd_en`=1 and `data_count`=0 → RD_ERROR.
- Read accepted (entering READ):
  - `d_out` ← `reg_bank` entry at the pre-edge `rd_ptr`.
  - `rd_ptr` ← `rd_ptr`+1, modulo 8, so 7 wraps to 0.
  - `rd_ack`=1 and `rd_err`=0.
- Read rejected (entering RD_ERROR):
  - `rd_err`=1 and `rd_ack`=0.
  - `rd_ptr` and `data_count` are unchanged.
  - `d_out` behaviour is set by the configuration macro.
- NO_OP: `rd_ack`=0 and `rd_err`=0.
- `data_count` update on each edge:
  - +1 on `wr_ack`.
  - −1 on an accepted read.
  - Unchanged when both happen.
- Boundary rules:
  - `wr_ack` while `data_count`=8 is a write-side violation. It is ignored and the count saturates at 8.
  - `wr_ack` together with `rd_en` while empty: the read is rejected (RD_ERROR), because the count is sampled before the edge. The count becomes 1.
  - A read together with `wr_ack` while full: the read is accepted and the count stays 8.
- `empty` and `full` are combinational decodes of the registered `data_count`.

## Timing
- Reset values, all outputs:
  - `d_out`=32'h0000_0000, `rd_ack`=0, `rd_err`=0.
  - `rd_ptr`=0, `data_count`=0.
  - `empty`=1, `full`=0.
  - State=INIT.
- Read latency is 1 cycle. With `rd_en` high at edge N, `d_out`, `rd_ack` and `rd_err` are valid after edge N. They hold for exactly one cycle unless `rd_en` stays high.
- Back-to-back reads are allowed, at one word per cycle while `data_count`>0.
- Asserting `reset_n` low mid-operation immediately forces every output to its reset value, without waiting for a clock edge.
- Release of `reset_n` is synchronous in effect. The first edge after release only performs INIT→NO_OP.

## Configuration
- Macro: `FIFO_RD_HOLD_EN`.
- When defined:
  - `d_out` keeps the last successfully read word through NO_OP and RD_ERROR cycles.
- When undefined:
  - `d_out` is driven to 0 in every cycle that is not READ.

## Test plan
- Reset mid-stream:
  - Stimulus: 3 `wr_ack` pulses, 1 read, then `reset_n`=0 asynchronously.
  - Required: all outputs return to reset values at once, and `empty`=1.
- Fill and drain with wrap:
  - Stimulus: `reg_bank` entries set to 32'h1000_0000+i; start from `rd_ptr` preloaded to 6 by 6 write/read pairs; then 4 `wr_ack` pulses, then 4 reads.
  - Required: `d_out` = 32'h1000_0006, 32'h1000_0007, 32'h1000_0000, 32'h1000_0001, with `rd_ack`=1 on each.
- Empty read:
  - Stimulus: `rd_en`=1 with `data_count`=0.
  - Required: `rd_err`=1, `rd_ack`=0, and `rd_ptr` and `data_count` unchanged.
  - Required `d_out`: 0 without `FIFO_RD_HOLD_EN`; the previous word with it.
- Simultaneous read and write at `data_count`=8:
  - Required: read accepted, `data_count` stays 8, `full`=1.
- Overflow `wr_ack`:
  - Stimulus: 9 `wr_ack` pulses.
  - Required: `data_count`=8, `full`=1, no wrap of the count to 0.
- Simultaneous `wr_ack` and `rd_en` while empty:
  - Required: `rd_err`=1, `data_count`=1.
  - Required: the next read returns the entry at `rd_ptr`=0 with `rd_ack`=1.

Source files
------------

// File: rtl/fifo_rd_port_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_port_if
// Bundle of the FIFO read-port signals that are shared between the read port
// and its neighbours (write side, consumer).
//
//   rd_en      read request into the port
//   wr_ack     one-cycle pulse from the write side: a word was stored
//   reg_bank   flattened 8 x 32-bit register bank, entry i at [32i+31:32i]
//   d_out      read data
//   rd_ack     read succeeded this cycle
//   rd_err     read attempted while empty
//   rd_ptr     index of the next entry to read (used by the write side)
//   data_count occupancy, 0..8
//   empty      data_count == 0
//   full       data_count == 8
//
// Modports:
//   master  - the environment side (drives requests, bank and write pulses)
//   slave   - the read port itself
// ---------------------------------------------------------------------------
interface fifo_rd_port_if;

    logic         rd_en;
    logic         wr_ack;
    logic [255:0] reg_bank;
    logic [31:0]  d_out;
    logic         rd_ack;
    logic         rd_err;
    logic [2:0]   rd_ptr;
    logic [3:0]   data_count;
    logic         empty;
    logic         full;

    modport master (
        output rd_en,
        output wr_ack,
        output reg_bank,
        input  d_out,
        input  rd_ack,
        input  rd_err,
        input  rd_ptr,
        input  data_count,
        input  empty,
        input  full
    );

    modport slave (
        input  rd_en,
        input  wr_ack,
        input  reg_bank,
        output d_out,
        output rd_ack,
        output rd_err,
        output rd_ptr,
        output data_count,
        output empty,
        output full
    );

endinterface

// File: rtl/fifo_rd_port.sv
// ---------------------------------------------------------------------------
// fifo_rd_port
// Read end of an 8-deep x 32-bit FIFO. Owns the read pointer, the occupancy
// count and the empty/full flags, and returns one word per accepted read with
// a one-cycle registered latency. Reads from an empty FIFO raise rd_err.
//
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous, active-low reset
//   bus      fifo_rd_port_if.slave (rd_en, wr_ack, reg_bank in;
//            d_out, rd_ack, rd_err, rd_ptr, data_count, empty, full out)
//
// Configuration:
//   FIFO_RD_HOLD_EN  when defined, d_out keeps the last successfully read
//                    word through non-READ cycles; otherwise d_out is 0 in
//                    every cycle that is not READ.
// ---------------------------------------------------------------------------
module fifo_rd_port (
    input  logic           clk,
    input  logic           reset_n,
    fifo_rd_port_if.slave  bus
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        NO_OP    = 2'd1,
        READ     = 2'd2,
        RD_ERROR = 2'd3
    } state_t;

`ifdef FIFO_RD_HOLD_EN
    localparam bit HOLD_DOUT = 1'b1;
`else
    localparam bit HOLD_DOUT = 1'b0;
`endif

    state_t      state;
    logic [31:0] d_out_q;
    logic        rd_ack_q;
    logic        rd_err_q;
    logic [2:0]  rd_ptr_q;
    logic [3:0]  count_q;

    logic        read_ok;
    logic [31:0] bank_word;
    logic [31:0] idle_dout;
    logic [3:0]  count_next;

    // The read decision uses the pre-edge count, so a write arriving on the
    // same edge as a read from empty cannot rescue that read.
    assign read_ok   = bus.rd_en && (count_q != 4'd0);
    assign bank_word = bus.reg_bank[{rd_ptr_q, 5'b00000} +: 32];
    assign idle_dout = HOLD_DOUT ? d_out_q : 32'h0000_0000;

    // A simultaneous write and accepted read cancel out; a lone write at
    // full is a write-side violation and is dropped so the count saturates.
    always_comb begin
        count_next = count_q;
        if (bus.wr_ack && !read_ok) begin
            if (count_q != 4'd8) begin
                count_next = count_q + 4'd1;
            end
        end else if (!bus.wr_ack && read_ok) begin
            count_next = count_q - 4'd1;
        end
    end

    // INIT only performs the hop to NO_OP; requests and write pulses on that
    // first edge after reset release are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            d_out_q  <= 32'h0000_0000;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
        end else begin
            case (state)
                INIT: begin
                    state    <= NO_OP;
                    rd_ack_q <= 1'b0;
                    rd_err_q <= 1'b0;
                    d_out_q  <= idle_dout;
                end
                default: begin
                    count_q <= count_next;
                    if (read_ok) begin
                        state    <= READ;
                        d_out_q  <= bank_word;
                        rd_ptr_q <= rd_ptr_q + 3'd1;
                        rd_ack_q <= 1'b1;
                        rd_err_q <= 1'b0;
                    end else if (bus.rd_en) begin
                        state    <= RD_ERROR;
                        d_out_q  <= idle_dout;
                        rd_ack_q <= 1'b0;
                        rd_err_q <= 1'b1;
                    end else begin
                        state    <= NO_OP;
                        d_out_q  <= idle_dout;
                        rd_ack_q <= 1'b0;
                        rd_err_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.d_out      = d_out_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.data_count = count_q;
    assign bus.empty      = (count_q == 4'd0);
    assign bus.full       = (count_q == 4'd8);

endmodule

// File: tb/tb_fifo_rd_port.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_port
// Scoreboard bench for fifo_rd_port. The driver computes the expected
// post-edge outputs from an occupancy/pointer model and queues them; a
// separate monitor pops one entry after each clock edge and compares.
// Honours FIFO_RD_HOLD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fifo_rd_port;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fifo_rd_port_if bus();

    fifo_rd_port dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef FIFO_RD_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic [31:0] d_out;
        logic        rd_ack;
        logic        rd_err;
        logic [2:0]  rd_ptr;
        logic [3:0]  data_count;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t exp_q[$];

    int num_checks = 0;
    int num_errors = 0;

    // reference model state
    int          m_count;
    int          m_ptr;
    logic [31:0] m_last;
    bit          m_init;
    logic [31:0] bank [8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_count = 0;
        m_ptr   = 0;
        m_last  = 32'h0;
        m_init  = 1'b1;
    endtask

    // Drive one cycle of stimulus at the falling edge, predict the outputs
    // after the next rising edge, queue the prediction, then wait for that edge.
    task automatic applyStimulus(input bit rd, input bit wr);
        exp_t e;
        bit   accept;
        @(negedge clk);
        bus.rd_en  = rd;
        bus.wr_ack = wr;
        for (int i = 0; i < 8; i++) bus.reg_bank[32*i +: 32] = bank[i];
        accept   = 1'b0;
        e.rd_err = 1'b0;
        if (m_init) begin
            m_init = 1'b0;
        end else begin
            accept   = rd && (m_count > 0);
            e.rd_err = rd && (m_count == 0);
            if (accept) begin
                m_last = bank[m_ptr];
                m_ptr  = (m_ptr + 1) % 8;
            end
            m_count = m_count + int'(wr) - int'(accept);
            if (m_count > 8) m_count = 8;
        end
        e.rd_ack     = accept;
        e.d_out      = (accept || HOLD) ? m_last : 32'h0;
        e.rd_ptr     = 3'(m_ptr);
        e.data_count = 4'(m_count);
        e.empty      = (m_count == 0);
        e.full       = (m_count == 8);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_d_out"},      bus.d_out,      32'h0);
        checkOutput({tag, "_rd_ack"},     bus.rd_ack,     32'h0);
        checkOutput({tag, "_rd_err"},     bus.rd_err,     32'h0);
        checkOutput({tag, "_rd_ptr"},     bus.rd_ptr,     32'h0);
        checkOutput({tag, "_data_count"}, bus.data_count, 32'h0);
        checkOutput({tag, "_empty"},      bus.empty,      32'h1);
        checkOutput({tag, "_full"},       bus.full,       32'h0);
    endtask

    // Assert reset between edges, check outputs at once, then release just
    // after a rising edge so the next driven cycle is the INIT edge.
    task automatic doReset(input string tag);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues(tag);
        modelReset();
        bus.rd_en  = 1'b0;
        bus.wr_ack = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("d_out",      bus.d_out,      e.d_out);
                checkOutput("rd_ack",     bus.rd_ack,     e.rd_ack);
                checkOutput("rd_err",     bus.rd_err,     e.rd_err);
                checkOutput("rd_ptr",     bus.rd_ptr,     e.rd_ptr);
                checkOutput("data_count", bus.data_count, e.data_count);
                checkOutput("empty",      bus.empty,      e.empty);
                checkOutput("full",       bus.full,       e.full);
            end
        end
    end

    initial begin
        bus.rd_en    = 1'b0;
        bus.wr_ack   = 1'b0;
        bus.reg_bank = '0;
        for (int i = 0; i < 8; i++) bank[i] = 32'h1000_0000 + i;
        modelReset();

        #3;
        checkResetValues("por");
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // INIT edge ignores the request; then a read from empty is rejected
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);

        // write and read together while empty: rejected, count becomes 1,
        // then the next read returns entry 0
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);

        // overflow: 9 write pulses saturate at 8
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1);
        // read together with write at full
        applyStimulus(1'b1, 1'b1);
        // drain plus one empty read (hold behaviour on d_out)
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // reset mid-stream after 3 writes and a read
        doReset("rst_a");
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        doReset("rst_b");

        // fill and drain with wrap: preload rd_ptr to 6
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // randomized traffic with changing bank contents
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) bank[$urandom_range(0, 7)] = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 55));
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
